dm_arbiter: RTL and testbench

Shares the single-port data memory `dm` between two requesters: the pipeline MEM stage (CPU) and a burst DMA/loader engine. Each cycle it grants the memory to exactly one requester. The CPU has priority, but the DMA is guaranteed one beat after a bounded number of consecutive CPU grants. The block sits between the MEM stage, the DMA engine and `dm`. It drives `dm`'s address, write-data and write-enable inputs, and stalls the pipeline when the DMA takes the slot.

---
 rtl/dm_arbiter_pkg.sv | 24 ++
 rtl/dm_arbiter_if.sv | 59 +++++
 rtl/dm_arb_starve_cnt.sv | 45 ++++
 rtl/dm_arbiter.sv | 113 +++++++++++
 tb/tb_dm_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the data-memory arbiter slice:
//   - arb_state_e    : arbiter FSM state encoding (IDLE / RUN)
//   - DM_*_DEF       : default address width, data width and starvation limit
//   - cnt_width()    : width of the starvation counter for a given limit
// ---------------------------------------------------------------------------
package dm_arbiter_pkg;

  localparam int DM_AW_DEF       = 10;
  localparam int DM_DW_DEF       = 32;
  localparam int DM_MAX_WAIT_DEF = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  // Counter must hold 0..max_wait; never narrower than one bit.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the three buses around the arbiter:
//   cpu_* : MEM-stage request/response
//   dma_* : burst engine control, per-beat data and status
//   dm_*  : single-port data memory (addr/din/we out, asynchronous dout in)
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (CPU, DMA engine, memory)
// ---------------------------------------------------------------------------
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int AW = DM_AW_DEF,
  parameter int DW = DM_DW_DEF
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dma_start;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [AW-1:0] dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_beat;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          dma_busy;
  logic          dma_done;

  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic          dm_we;
  logic [DW-1:0] dm_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_start, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_beat, dma_rdata, dma_rvalid, dma_busy, dma_done,
    output dm_addr, dm_din, dm_we,
    input  dm_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_start, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_beat, dma_rdata, dma_rvalid, dma_busy, dma_done,
    input  dm_addr, dm_din, dm_we,
    output dm_dout
  );

endinterface

// File: rtl/dm_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// dm_arb_starve_cnt
// Counts consecutive CPU grants while a DMA burst is pending and flags when
// the DMA must be given the next slot.
// Ports:
//   clk   in  : clock
//   rst   in  : asynchronous active-low reset
//   i_inc in  : CPU took the slot from a pending burst (saturating increment)
//   i_clr in  : clear the count (DMA beat or burst launch); wins over i_inc
//   o_hit out : count has reached MAX_WAIT
// ---------------------------------------------------------------------------
module dm_arb_starve_cnt
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DM_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam int            CW    = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // With MAX_WAIT = 0 the count is pinned at 0, so hit is constantly high and
  // the DMA wins every cycle.
  assign o_hit = (r_cnt == MAX_C);

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Shares the single-port data memory between the MEM stage (priority) and a
// burst DMA engine, guaranteeing the DMA one beat after at most MAX_WAIT
// consecutive CPU grants.
// Ports:
//   clk in : clock, all state changes on the rising edge
//   rst in : asynchronous active-low reset
//   bus     : dm_arbiter_if.slave -- CPU request/response, DMA control and
//             status, and the memory address/data/write-enable/read-data
// ---------------------------------------------------------------------------
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW       = DM_AW_DEF,
  parameter int DW       = DM_DW_DEF,
  parameter int MAX_WAIT = DM_MAX_WAIT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dm_arbiter_if.slave    bus
);

  arb_state_e    r_state;
  logic          r_dir;
  logic [AW-1:0] r_cur_addr;
  logic [AW-1:0] r_remain;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_done;

  logic w_run;
  logic w_hit;
  logic w_beat;
  logic w_inc;
  logic w_clr;

  assign w_run  = (r_state == ARB_RUN);
  assign w_beat = w_run & (~bus.cpu_req | w_hit);
  assign w_inc  = w_run & ~w_beat;
  assign w_clr  = w_beat | (~w_run & bus.dma_start);

  dm_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_dir      <= 1'b0;
      r_cur_addr <= '0;
      r_remain   <= '0;
      // NOTE: the read-data register is reset too, so dma_rdata reads 0 after
      // reset instead of stale data from an abandoned burst.
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (bus.dma_start) begin
            r_dir      <= bus.dma_we;
            r_cur_addr <= bus.dma_addr;
            r_remain   <= bus.dma_len;
            r_state    <= ARB_RUN;
          end
        end
        ARB_RUN: begin
          // dma_start is deliberately ignored here: a pulse during a burst is
          // dropped, not queued.
          if (w_beat) begin
            r_cur_addr <= r_cur_addr + AW'(1);
            if (!r_dir) begin
              r_rdata  <= bus.dm_dout;
              r_rvalid <= 1'b1;
            end
            if (r_remain == '0) begin
              r_state <= ARB_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_remain <= r_remain - AW'(1);
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // The memory port follows the grant; a stalled CPU store therefore never
  // reaches dm_we.
  assign bus.dm_addr    = w_beat ? r_cur_addr    : bus.cpu_addr;
  assign bus.dm_din     = w_beat ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.dm_we      = w_beat ? r_dir         : (bus.cpu_req & bus.cpu_we);

  assign bus.cpu_rdata  = bus.dm_dout;
  assign bus.cpu_stall  = bus.cpu_req & w_beat;

  assign bus.dma_beat   = w_beat;
  assign bus.dma_rdata  = r_rdata;
  assign bus.dma_rvalid = r_rvalid;
  assign bus.dma_busy   = w_run;
  assign bus.dma_done   = r_done;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
// Runs two arbiters in lockstep on the same stimulus: unit a with
// MAX_WAIT = 4 and unit b with MAX_WAIT = 0. Each has its own data memory and
// its own reference model (grant rule, burst bookkeeping, memory image).
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, dma_start, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, dma_len;
  logic [DW-1:0] cpu_wdata, dma_wdata;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
  dm_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

  assign bus_a.cpu_req = cpu_req;     assign bus_b.cpu_req = cpu_req;
  assign bus_a.cpu_we = cpu_we;       assign bus_b.cpu_we = cpu_we;
  assign bus_a.cpu_addr = cpu_addr;   assign bus_b.cpu_addr = cpu_addr;
  assign bus_a.cpu_wdata = cpu_wdata; assign bus_b.cpu_wdata = cpu_wdata;
  assign bus_a.dma_start = dma_start; assign bus_b.dma_start = dma_start;
  assign bus_a.dma_we = dma_we;       assign bus_b.dma_we = dma_we;
  assign bus_a.dma_addr = dma_addr;   assign bus_b.dma_addr = dma_addr;
  assign bus_a.dma_len = dma_len;     assign bus_b.dma_len = dma_len;
  assign bus_a.dma_wdata = dma_wdata; assign bus_b.dma_wdata = dma_wdata;

  // Data memories, cleared by the same reset.
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  assign bus_a.dm_dout = mem_a[bus_a.dm_addr];
  assign bus_b.dm_dout = mem_b[bus_b.dm_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) for (int i = 0; i < DEPTH; i++) mem_a[i] <= '0;
    else if (bus_a.dm_we) mem_a[bus_a.dm_addr] <= bus_a.dm_din;
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) for (int j = 0; j < DEPTH; j++) mem_b[j] <= '0;
    else if (bus_b.dm_we) mem_b[bus_b.dm_addr] <= bus_b.dm_din;
  end

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- checking ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_busy [2];
  bit            m_dir [2];
  bit            m_done [2];
  bit            m_rvalid [2];
  int            m_addr [2];
  int            m_left [2];   // beats still owed in the burst
  int            m_streak [2]; // CPU grants since the DMA last moved
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [2][DEPTH];
  bit            p_beat [2];

  function automatic int max_wait(input int u);
    return (u == 0) ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_dir[u] = 0; m_done[u] = 0; m_rvalid[u] = 0;
      m_addr[u] = 0; m_left[u] = 0; m_streak[u] = 0; m_rdata[u] = '0;
      p_beat[u] = 0;
      for (int k = 0; k < DEPTH; k++) ref_mem[u][k] = '0;
    end
  endtask

  task automatic check_unit(input int u, input logic beat, stall, we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] din, crd,
                            input logic busy, done, rvalid, input logic [DW-1:0] rd);
    string s;
    bit    eb;
    s  = (u == 0) ? "a" : "b";
    eb = m_busy[u] && (!cpu_req || (m_streak[u] >= max_wait(u)));
    p_beat[u] = eb;
    check({s, "_dma_beat"}, beat, eb);
    check({s, "_cpu_stall"}, stall, cpu_req && eb);
    check({s, "_dm_we"}, we, eb ? m_dir[u] : (cpu_req && cpu_we));
    check({s, "_dm_addr"}, addr, eb ? 64'(m_addr[u]) : cpu_addr);
    check({s, "_dm_din"}, din, eb ? dma_wdata : cpu_wdata);
    if (cpu_req && !cpu_we && !eb) check({s, "_cpu_rdata"}, crd, ref_mem[u][cpu_addr]);
    check({s, "_dma_busy"}, busy, m_busy[u]);
    check({s, "_dma_done"}, done, m_done[u]);
    check({s, "_dma_rvalid"}, rvalid, m_rvalid[u]);
    check({s, "_dma_rdata"}, rd, m_rdata[u]);
  endtask

  task automatic model_edge(input int u);
    bit eb;
    eb = p_beat[u];
    m_done[u]   = 0;
    m_rvalid[u] = 0;
    if (cpu_req && cpu_we && !eb) ref_mem[u][cpu_addr] = cpu_wdata;
    if (m_busy[u]) begin
      if (eb) begin
        if (m_dir[u]) ref_mem[u][m_addr[u]] = dma_wdata;
        else begin
          m_rdata[u]  = ref_mem[u][m_addr[u]];
          m_rvalid[u] = 1;
        end
        m_addr[u]   = (m_addr[u] + 1) % DEPTH;
        m_left[u]   = m_left[u] - 1;
        m_streak[u] = 0;
        if (m_left[u] == 0) begin
          m_busy[u] = 0;
          m_done[u] = 1;
        end
      end else if (m_streak[u] < max_wait(u)) begin
        m_streak[u]++;
      end
    end else if (dma_start) begin
      m_busy[u]   = 1;
      m_dir[u]    = dma_we;
      m_addr[u]   = int'(dma_addr);
      m_left[u]   = int'(dma_len) + 1;
      m_streak[u] = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_unit(0, bus_a.dma_beat, bus_a.cpu_stall, bus_a.dm_we, bus_a.dm_addr, bus_a.dm_din,
               bus_a.cpu_rdata, bus_a.dma_busy, bus_a.dma_done, bus_a.dma_rvalid, bus_a.dma_rdata);
    check_unit(1, bus_b.dma_beat, bus_b.cpu_stall, bus_b.dm_we, bus_b.dm_addr, bus_b.dm_din,
               bus_b.cpu_rdata, bus_b.dma_busy, bus_b.dma_done, bus_b.dma_rvalid, bus_b.dma_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'(1020 + $urandom_range(0, 3));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] wlog [3];
    logic [DW-1:0] v_hi, v_lo;
    int            nb_a, nb_b, mism_a, mism_b;

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_start = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;

    // Reset
    #2 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_busy", bus_a.dma_busy, 0);
    check("rst_a_beat", bus_a.dma_beat, 0);
    check("rst_a_rdata", bus_a.dma_rdata, 0);
    check("rst_a_dm_we", bus_a.dm_we, 0);
    rst = 1'b1;
    tick();

    // CPU store then load, no DMA
    cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
    tick();
    cpu_we = 0;
    sample();
    check("cpu_load_a", bus_a.cpu_rdata, 32'hDEADBEEF);
    check("cpu_load_stall", bus_a.cpu_stall, 0);
    advance();

    // Write burst of 3 at addr 10 with the CPU asking every cycle
    dma_start = 1; dma_we = 1; dma_addr = 10; dma_len = 2;
    tick();
    dma_start = 0;
    for (int k = 1; k <= 17; k++) begin
      cpu_addr = AW'(20 + $urandom_range(0, 7));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      sample();
      check($sformatf("burst_a_beat_k%0d", k), bus_a.dma_beat, (k % 5 == 0) && (k <= 15));
      check($sformatf("burst_a_stall_k%0d", k), bus_a.cpu_stall, (k % 5 == 0) && (k <= 15));
      check($sformatf("burst_b_beat_k%0d", k), bus_b.dma_beat, k <= 3);
      check($sformatf("burst_a_done_k%0d", k), bus_a.dma_done, k == 16);
      check($sformatf("burst_b_done_k%0d", k), bus_b.dma_done, k == 4);
      if ((k % 5 == 0) && (k <= 15)) wlog[k/5 - 1] = dma_wdata;
      advance();
    end
    for (int i = 0; i < 3; i++) check($sformatf("burst_mem_%0d", 10 + i), mem_a[10 + i], wlog[i]);

    // Stalled CPU stores must not reach memory (unit b), granted ones must (unit a)
    cpu_req = 0;
    dma_start = 1; dma_we = 1; dma_addr = 400; dma_len = 3;
    tick();
    dma_start = 0;
    for (int k = 1; k <= 4; k++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 300; cpu_wdata = 32'hA5A50000 | DW'(k);
      dma_wdata = $urandom;
      sample();
      check($sformatf("strict_b_stall_k%0d", k), bus_b.cpu_stall, 1);
      check($sformatf("strict_b_dm_we_k%0d", k), bus_b.dm_addr == 300 && bus_b.dm_we, 0);
      advance();
    end
    cpu_req = 0;
    repeat (8) tick();
    check("strict_b_mem300", mem_b[300], 0);
    check("strict_a_mem300", mem_a[300], 32'hA5A50004);

    // Read burst of 2 from addr 1023 with an idle CPU: wraps to 0
    v_hi = $urandom; v_lo = $urandom;
    cpu_req = 1; cpu_we = 1; cpu_addr = 1023; cpu_wdata = v_hi; tick();
    cpu_addr = 0; cpu_wdata = v_lo; tick();
    cpu_req = 0; cpu_we = 0;
    dma_start = 1; dma_we = 0; dma_addr = 1023; dma_len = 1;
    tick();
    dma_start = 0;
    sample();
    check("wrap_addr0", bus_a.dm_addr, 1023);
    check("wrap_beat0", bus_a.dma_beat, 1);
    advance();
    sample();
    check("wrap_addr1", bus_a.dm_addr, 0);
    check("wrap_rvalid0", bus_a.dma_rvalid, 1);
    check("wrap_rdata0", bus_a.dma_rdata, v_hi);
    advance();
    sample();
    check("wrap_rvalid1", bus_b.dma_rvalid, 1);
    check("wrap_rdata1", bus_b.dma_rdata, v_lo);
    check("wrap_done", bus_a.dma_done, 1);
    advance();

    // dma_start during RUN is dropped
    dma_start = 1; dma_we = 0; dma_addr = 50; dma_len = 2;
    tick();
    dma_start = 0;
    nb_a = 0; nb_b = 0;
    for (int k = 1; k <= 20; k++) begin
      cpu_req = 1'($urandom_range(0, 1)); cpu_we = 0; cpu_addr = rand_addr();
      if (k == 2) begin
        dma_start = 1; dma_we = 1; dma_addr = 600; dma_len = 7;
      end else dma_start = 0;
      sample();
      if (bus_a.dma_beat) nb_a++;
      if (bus_b.dma_beat) nb_b++;
      advance();
    end
    check("restart_a_beats", nb_a, 3);
    check("restart_b_beats", nb_b, 3);
    check("restart_a_idle", bus_a.dma_busy, 0);

    // Reset in the middle of a burst, then a fresh burst
    cpu_req = 0;
    dma_start = 1; dma_we = 1; dma_addr = 700; dma_len = 5;
    tick();
    dma_start = 0;
    tick(); tick();
    cpu_req = 1; cpu_we = 0;
    rst = 1'b0;
    #1;
    check("midrst_a_beat", bus_a.dma_beat, 0);
    check("midrst_a_busy", bus_a.dma_busy, 0);
    check("midrst_a_stall", bus_a.cpu_stall, 0);
    check("midrst_a_done", bus_a.dma_done, 0);
    check("midrst_a_rvalid", bus_a.dma_rvalid, 0);
    check("midrst_a_rdata", bus_a.dma_rdata, 0);
    check("midrst_b_busy", bus_b.dma_busy, 0);
    model_reset();
    tick(); tick();
    rst = 1'b1;
    cpu_req = 0;
    dma_start = 1; dma_we = 0; dma_addr = 700; dma_len = 1;
    tick();
    dma_start = 0;
    nb_a = 0;
    for (int k = 1; k <= 4; k++) begin
      sample();
      if (bus_a.dma_beat) nb_a++;
      advance();
    end
    check("postrst_a_beats", nb_a, 2);

    // Random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      cpu_req   = ($urandom_range(0, 9) < 6);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = rand_addr();
      cpu_wdata = $urandom;
      dma_start = ($urandom_range(0, 5) == 0);
      dma_we    = 1'($urandom_range(0, 1));
      dma_addr  = rand_addr();
      dma_len   = AW'($urandom_range(0, 3));
      dma_wdata = $urandom;
      tick();
    end
    cpu_req = 0; dma_start = 0;
    repeat (20) tick();

    mism_a = 0; mism_b = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (mem_a[k] !== ref_mem[0][k]) mism_a++;
      if (mem_b[k] !== ref_mem[1][k]) mism_b++;
    end
    check("final_mem_a_mismatches", mism_a, 0);
    check("final_mem_b_mismatches", mism_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
